// File: rtl/sw_loader_pkg.sv
// Shared constants for the switch-driven word loader: FSM encoding,
// debounce default and lane geometry.
package sw_loader_pkg;

    localparam int DEB_CYCLES_DEF = 1000000;
    localparam int NUM_LANES      = 4;

    localparam logic [1:0] LANE_LAST = 2'(NUM_LANES - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_WRITE   = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

endpackage

// File: rtl/key_debounce.sv
// Push-button front end: 2-flop synchronizer, stability-count debouncer
// and a one-cycle pulse on each accepted press (release is silent).
module key_debounce
    import sw_loader_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clka,
    input  logic rsta,
    input  logic key_xi,
    output logic press_xo
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_count;

    logic w_differs;
    logic w_accept;

    assign w_differs = (r_sync2 != r_level);
    // The DEB_CYCLES-th consecutive mismatching cycle flips the level.
    assign w_accept  = w_differs && (r_count == CNT_W'(DEB_CYCLES - 1));

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking here would collapse the synchronizer into a single stage.
    always_ff @(posedge clka) begin
        if (rsta) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= key_xi;
            r_sync2 <= r_sync1;
            r_press <= w_accept && r_sync2;
            if (w_accept) begin
                r_level <= r_sync2;
                r_count <= '0;
            end else if (w_differs) begin
                r_count <= r_count + 1'b1;
            end else begin
                r_count <= '0;
            end
        end
    end

    assign press_xo = r_press;

endmodule

// File: rtl/sw_word_loader.sv
// Assembles four switch bytes per word from debounced key presses and
// emits one write strobe per word until the address space is full.
module sw_word_loader
    import sw_loader_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int ADDR_W     = 6
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              key_xi,
    input  logic [7:0]        sw_xi,
    output logic              wea_xo,
    output logic [ADDR_W-1:0] addra_xo,
    output logic [31:0]       dina_xo,
    output logic [1:0]        byte_idx_xo,
    output logic [7:0]        led_xo,
    output logic              full_xo
);

    logic              w_press;

    logic [1:0]        r_state;
    logic [7:0]        r_lanes [NUM_LANES];
    logic [1:0]        r_byte_idx;
    logic [7:0]        r_led;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_dina;

    key_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_key_debounce (
        .clka     (clka),
        .rsta     (rsta),
        .key_xi   (key_xi),
        .press_xo (w_press)
    );

    always_ff @(posedge clka) begin
        if (rsta) begin
            r_state    <= S_COLLECT;
            r_byte_idx <= 2'd0;
            r_led      <= 8'd0;
            r_addr     <= '0;
            r_dina     <= 32'd0;
            // NOTE: the lane array is reset on purpose: a partial word must
            // not leak into the next write after rsta.
            for (int i = 0; i < NUM_LANES; i++) begin
                r_lanes[i] <= 8'd0;
            end
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_press) begin
                        r_lanes[r_byte_idx] <= sw_xi;
                        r_led               <= sw_xi;
                        r_byte_idx          <= r_byte_idx + 2'd1;
                        if (r_byte_idx == LANE_LAST) begin
                            r_state <= S_WRITE;
                            r_dina  <= {sw_xi, r_lanes[2], r_lanes[1], r_lanes[0]};
                        end
                    end
                end
                S_WRITE: begin
                    // The last address parks the loader instead of wrapping.
                    if (r_addr == '1) begin
                        r_state <= S_FULL;
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= S_COLLECT;
                    end
                end
                S_FULL: begin
                    r_state <= S_FULL;
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    assign wea_xo      = (r_state == S_WRITE);
    assign full_xo     = (r_state == S_FULL);
    assign addra_xo    = r_addr;
    assign dina_xo     = r_dina;
    assign byte_idx_xo = r_byte_idx;
    assign led_xo      = r_led;

endmodule

// File: tb/tb_sw_word_loader.sv
// Randomized scoreboard bench for sw_word_loader with a word-level
// reference model (DEB_CYCLES=4, ADDR_W=2).
module tb_sw_word_loader;

    localparam int DEB = 4;
    localparam int AW  = 2;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clka = 1'b0;
    logic          rsta;
    logic          key_xi;
    logic [7:0]    sw_xi;
    logic          wea_xo;
    logic [AW-1:0] addra_xo;
    logic [31:0]   dina_xo;
    logic [1:0]    byte_idx_xo;
    logic [7:0]    led_xo;
    logic          full_xo;

    int  n_vec = 0;
    int  n_err = 0;
    wr_t exp_q[$];

    // Reference model state
    logic [7:0]  m_lanes [4];
    int          m_idx;
    logic [7:0]  m_led;
    int          m_addr;
    bit          m_full;
    logic [31:0] m_word;

    sw_word_loader #(
        .DEB_CYCLES (DEB),
        .ADDR_W     (AW)
    ) dut (
        .clka        (clka),
        .rsta        (rsta),
        .key_xi      (key_xi),
        .sw_xi       (sw_xi),
        .wea_xo      (wea_xo),
        .addra_xo    (addra_xo),
        .dina_xo     (dina_xo),
        .byte_idx_xo (byte_idx_xo),
        .led_xo      (led_xo),
        .full_xo     (full_xo)
    );

    always #5 clka = ~clka;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_lanes[i] = 8'd0;
        m_idx  = 0;
        m_led  = 8'd0;
        m_addr = 0;
        m_full = 1'b0;
        m_word = 32'd0;
        exp_q.delete();
    endfunction

    // One accepted press: fill the next byte, emit a word every 4 bytes.
    function automatic void model_press(input logic [7:0] b);
        wr_t w;
        if (m_full) return;
        m_lanes[m_idx] = b;
        m_led          = b;
        if (m_idx == 3) begin
            m_word = {m_lanes[3], m_lanes[2], m_lanes[1], m_lanes[0]};
            w.addr = AW'(m_addr);
            w.data = m_word;
            exp_q.push_back(w);
            if (m_addr == (1 << AW) - 1) m_full = 1'b1;
            else                         m_addr++;
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clka);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".led"},  32'(led_xo),      32'(m_led));
        check({tag, ".idx"},  32'(byte_idx_xo), 32'(m_idx));
        check({tag, ".addr"}, 32'(addra_xo),    32'(m_addr));
        check({tag, ".full"}, 32'(full_xo),     32'(m_full));
        check({tag, ".dina"}, dina_xo,          m_word);
        check({tag, ".wea"},  32'(wea_xo),      32'd0);
    endtask

    task automatic press(input logic [7:0] b, input int hold, input string tag);
        model_press(b);
        sw_xi  = b;
        key_xi = 1'b1;
        tick(hold);
        key_xi = 1'b0;
        tick(12);
        check_state(tag);
    endtask

    task automatic do_reset(input string tag);
        rsta   = 1'b1;
        key_xi = 1'b0;
        tick(1);
        rsta = 1'b0;
        model_reset();
        check_state(tag);
    endtask

    // Monitor: every write strobe is matched against the scoreboard queue.
    bit prev_wea = 1'b0;
    always @(negedge clka) begin : mon
        wr_t e;
        if (wea_xo === 1'b1) begin
            check("wea_not_back_to_back", 32'(prev_wea), 32'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wea_unexpected: write addr %0d data %h, none expected", addra_xo, dina_xo);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(addra_xo), 32'(e.addr));
                check("wr_data", dina_xo, e.data);
            end
        end
        prev_wea = (wea_xo === 1'b1);
    end

    initial begin : stim
        logic [7:0] b;
        logic [7:0] pre_led;
        int         pre_idx;
        bit         found;

        rsta   = 1'b1;
        key_xi = 1'b0;
        sw_xi  = 8'd0;
        model_reset();
        tick(2);
        do_reset("reset");

        // Four clean presses build one word at address 0.
        press(8'h11, 10, "w0_b0");
        press(8'h22, 10, "w0_b1");
        press(8'h33, 10, "w0_b2");
        press(8'h44, 10, "w0_b3");
        check("w0_word", dina_xo, 32'h44332211);

        // Bouncing key: only the final stable level counts, with full latency.
        b       = 8'($urandom);
        pre_idx = m_idx;
        pre_led = m_led;
        sw_xi   = b;
        for (int s = 0; s < 10; s++) begin
            key_xi = (s % 2 == 0);
            tick(2);
        end
        model_press(b);
        key_xi = 1'b1;
        tick(6);
        check("bounce_no_early_idx", 32'(byte_idx_xo), 32'(pre_idx));
        check("bounce_no_early_led", 32'(led_xo), 32'(pre_led));
        tick(1);
        check("bounce_capture_idx", 32'(byte_idx_xo), 32'(m_idx));
        tick(10);
        key_xi = 1'b0;
        tick(12);
        check_state("bounce");

        // Long hold yields a single press.
        press(8'($urandom), 100, "hold100");

        // Random fill to the last address, then discarded presses.
        while (!m_full) begin
            press(8'($urandom), 10, "fill");
        end
        check("full_addr", 32'(addra_xo), 32'((1 << AW) - 1));
        press(8'($urandom), 10, "after_full_a");
        press(8'($urandom), 10, "after_full_b");

        // Partial word discarded by reset; new word starts clean at 0.
        do_reset("reset2");
        press(8'($urandom), 10, "part_b0");
        press(8'($urandom), 10, "part_b1");
        do_reset("reset_partial");
        for (int i = 0; i < 4; i++) begin
            press(8'($urandom), 10, "after_rst");
        end

        // Reset landing on the write cycle wins over the address increment.
        for (int i = 0; i < 3; i++) begin
            press(8'($urandom), 10, "rw_pre");
        end
        b = 8'($urandom);
        model_press(b);
        sw_xi  = b;
        key_xi = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (wea_xo === 1'b1) found = 1'b1;
        end
        check("rw_wea_seen", 32'(found), 32'd1);
        rsta   = 1'b1;
        key_xi = 1'b0;
        tick(1);
        check("rw_wea_after_rst", 32'(wea_xo), 32'd0);
        check("rw_addr_after_rst", 32'(addra_xo), 32'd0);
        check("rw_dina_after_rst", dina_xo, 32'd0);
        rsta = 1'b0;
        model_reset();
        tick(12);
        check_state("rw_idle");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sw_word_loader.md
SW_WORD_LOADER -- requirements
Module: sw_word_loader

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, SHALL set the number of consecutive stable clka cycles required to accept a key level change.
REQ-002 Parameter ADDR_W, default 6, SHALL set the write-address width; depth is 2^ADDR_W words.
REQ-003 clka  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rsta  input  1  SHALL be the reset: synchronous and active-high.
REQ-005 key_xi  input  1  SHALL be the raw, bouncy, asynchronous push-button that enters one byte per press.
REQ-006 sw_xi  input  8  SHALL be the byte value on the slide switches.
REQ-007 wea_xo  output  1  SHALL be the one-cycle memory write strobe.
REQ-008 addra_xo  output  ADDR_W  SHALL be the word address being filled.
REQ-009 dina_xo  output  32  SHALL be the assembled write word.
REQ-010 byte_idx_xo  output  2  SHALL be the lane the next press fills (0 = bits 7:0 ... 3 = bits 31:24).
REQ-011 led_xo  output  8  SHALL echo the most recently captured byte.
REQ-012 full_xo  output  1  SHALL indicate that all 2^ADDR_W words have been written.

Function
REQ-013 key_xi SHALL pass through a 2-flop synchronizer before any other use.
REQ-014 The debouncer SHALL change its filtered level only after the synchronized key differs from it for DEB_CYCLES consecutive cycles; any mismatch-free cycle resets the count.
REQ-015 A filtered 0->1 transition SHALL produce press_p high for exactly one cycle; release produces no pulse.
REQ-016 FSM states SHALL be S_COLLECT, S_WRITE and S_FULL.
REQ-017 In S_COLLECT with press_p high, sw_xi SHALL be stored in lane byte_idx_xo, led_xo SHALL be updated to sw_xi, and byte_idx_xo SHALL increment modulo 4, all on that edge.
REQ-018 A capture into lane 3 SHALL move the FSM to S_WRITE.
REQ-019 S_WRITE SHALL last exactly one cycle, with wea_xo=1, dina_xo={lane3,lane2,lane1,lane0} and addra_xo equal to the current address.
REQ-020 On leaving S_WRITE, addra_xo SHALL increment by 1.
REQ-021 If the written address was 2^ADDR_W-1, the FSM SHALL instead go to S_FULL, set full_xo=1 and hold addra_xo at 2^ADDR_W-1.
REQ-022 In all other cases S_WRITE SHALL return to S_COLLECT.
REQ-023 A press_p in S_WRITE or S_FULL SHALL be discarded, with no capture and no led_xo change.
REQ-024 S_FULL SHALL be left only by rsta.
REQ-025 wea_xo SHALL never be high in two consecutive cycles; dina_xo SHALL hold its value until the next write.
REQ-026 Latency SHALL be 2 sync cycles + DEB_CYCLES from a clean key edge to press_p, and 1 cycle from press_p to capture.

Reset
REQ-027 rsta high at a clock edge SHALL force the following: wea_xo=0, addra_xo=0, dina_xo=0, byte_idx_xo=0, led_xo=0, full_xo=0; byte lanes cleared; FSM=S_COLLECT; debouncer level=0 and count=0; synchronizer flops=0.
REQ-028 rsta SHALL take priority over every event in the same cycle, including a press_p or S_WRITE; a partial word SHALL be discarded.

Structure
REQ-029 Package sw_loader_pkg SHALL hold the FSM state encoding, the DEB_CYCLES default and the lane count (4).
REQ-030 Synchronizer plus debouncer plus edge pulse SHALL be one sub-module, key_debounce (ports clka, rsta, key_xi, press_xo); all other logic stays in sw_word_loader.

Verification (DEB_CYCLES=4, ADDR_W=2)
REQ-031 Clean press/release with sw_xi=8'h11, 22, 33, 44 in turn -> one wea_xo pulse with dina_xo=32'h44332211 and addra_xo=0; then addra_xo=1 and byte_idx_xo=0.
REQ-032 Key toggling every 2 cycles for 20 cycles, then held high -> exactly one capture, after 4 stable cycles.
REQ-033 Write 4 words -> after the 4th write, full_xo=1 and addra_xo=3; a further press leaves led_xo and byte_idx_xo unchanged.
REQ-034 Capture 2 bytes, then rsta for 1 cycle -> all outputs 0; the next 4 presses write at addra_xo=0 with only the new bytes.
REQ-035 rsta asserted in the S_WRITE cycle -> wea_xo=0 on that edge's outputs and addra_xo=0.
REQ-036 Key held high for 100 cycles -> exactly one press_p.
